// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: time-multiplexed scan for a common-anode hex display.
// Optional: define SEVENSEG_LZ_BLANK_EN for leading-zero suppression.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              dec_nibble,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DW    = 4 * NUM_DIGITS;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLK_END  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHW_END  = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  w_adv;
  logic                  w_frame;
  logic                  w_take;
  logic [DW-1:0]         r_active;
  logic [DW-1:0]         r_pending;
  logic [DW-1:0]         w_active_nxt;
  logic                  r_pend_full;
  logic [3:0]            r_nibble;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [NUM_DIGITS-1:0] w_en_eff;
  logic                  r_lit;
  logic                  w_lit_nxt;
  logic                  r_frame_start;

  assign w_take       = load_valid && !r_pend_full;
  assign w_active_nxt = (w_frame && r_pend_full) ? r_pending : r_active;

  // Slot sequencing: blank gap, then lit window, then advance digit
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_adv       = 1'b0;
    w_frame     = 1'b0;
    unique case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLK_END) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
        if (r_cnt == SHW_END) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_adv       = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            w_frame   = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
    endcase
  end

`ifdef SEVENSEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lz_mask;

  // Dark every leading zero digit; digit 0 always shows
  always_comb begin
    logic z;
    z         = 1'b1;
    w_lz_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      z            = z && (r_active[4*k +: 4] == 4'h0);
      w_lz_mask[k] = z;
    end
  end

  assign w_en_eff = digit_en & ~w_lz_mask;
`else
  assign w_en_eff = digit_en;
`endif

  // Anode pattern for the coming cycle, at most one digit lit
  always_comb begin
    w_lit_nxt = (w_state_nxt == ST_SHOW) && w_en_eff[w_idx_nxt];
    w_an_nxt  = '1;
    if (w_lit_nxt) begin
      w_an_nxt[w_idx_nxt] = 1'b0;
    end
  end

  // FSM state, prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Anodes and segment gate move on the same edge as the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_n        <= '1;
      r_lit         <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_an_n        <= w_an_nxt;
      r_lit         <= w_lit_nxt;
      r_frame_start <= w_frame;
    end
  end

  // Decoder input changes only when entering a blank gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nibble <= 4'h0;
    end else if (w_adv) begin
      r_nibble <= w_active_nxt[4*w_idx_nxt +: 4];
    end
  end

  // One-deep pending buffer, promoted to active at frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active    <= '0;
      r_pending   <= '0;
      r_pend_full <= 1'b0;
    end else if (w_take) begin
      r_pending   <= load_data;
      r_pend_full <= 1'b1;
    end else if (w_frame && r_pend_full) begin
      r_active    <= r_pending;
      r_pend_full <= 1'b0;
    end
  end

  assign load_ready  = !r_pend_full;
  assign dec_nibble  = r_nibble;
  assign an_n        = r_an_n;
  assign seg_out     = r_lit ? seg_in : 7'h00;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: scoreboard bench for the display scanner.
// Frame expectations are queued by stimulus, checked by the monitor.
module tb_sevenseg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  digit_en;
  logic [3:0]  dec_nibble;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  an_n;
  logic        frame_start;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  en;
  } exp_t;

  exp_t q[$];

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

`ifdef SEVENSEG_LZ_BLANK_EN
  function automatic logic [3:0] lz(input logic [15:0] v);
    logic [3:0] m;
    logic       z;
    m = 4'h0;
    z = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      z    = z && (v[k*4 +: 4] == 4'h0);
      m[k] = z;
    end
    return m;
  endfunction
`endif

  assign seg_in = hex7(dec_nibble);

  sevenseg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLANK_CYCLES(2),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .digit_en   (digit_en),
    .dec_nibble (dec_nibble),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .an_n       (an_n),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_frame();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!frame_start && g < 60);
    chk("sync_frame", 32'(frame_start), 32'd1);
  endtask

  task automatic push(input logic [15:0] v, input logic [3:0] e);
    exp_t x;
    x.val = v;
    x.en  = e;
    q.push_back(x);
  endtask

  // Monitor: a frame begins at reset release or at each frame_start
  initial begin : monitor
    exp_t       e;
    int         c;
    int         slot;
    int         ph;
    bit         inframe;
    bit         prev_hi;
    logic [3:0] en_eff;
    logic [3:0] nib;
    logic [3:0] ea;
    logic [6:0] es;
    logic       lit;
    c       = 0;
    inframe = 1'b0;
    prev_hi = 1'b0;
    e       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inframe = 1'b0;
        prev_hi = 1'b0;
      end else begin
        if (!prev_hi || frame_start) begin
          if (prev_hi) chk("frame_len", 32'(c), 32'd24);
          chk("sb_has_frame", 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) begin
            e       = q.pop_front();
            inframe = 1'b1;
          end else begin
            inframe = 1'b0;
          end
          c = 0;
        end
        if (inframe) begin
          if (c >= 24) begin
            chk("frame_start_due", 32'(frame_start), 32'd1);
            inframe = 1'b0;
          end else begin
            slot   = c / 6;
            ph     = c % 6;
`ifdef SEVENSEG_LZ_BLANK_EN
            en_eff = e.en & ~lz(e.val);
`else
            en_eff = e.en;
`endif
            nib    = e.val[slot*4 +: 4];
            lit    = (ph >= 2) && en_eff[slot];
            ea     = 4'hF;
            if (lit) ea[slot] = 1'b0;
            es     = lit ? hex7(nib) : 7'h00;
            chk("an_n", 32'(an_n), 32'(ea));
            chk("seg_out", 32'(seg_out), 32'(es));
            if (ph == 0) chk("dec_nibble", 32'(dec_nibble), 32'(nib));
          end
        end
        c++;
        prev_hi = 1'b1;
      end
    end
  end

  // Stimulus
  initial begin : stim
    int g;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    digit_en   = 4'hF;
    tick(3);
    chk("rst_an_n", 32'(an_n), 32'hF);
    chk("rst_seg", 32'(seg_out), 32'h0);
    chk("rst_nibble", 32'(dec_nibble), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_fs", 32'(frame_start), 32'd0);
    push(16'h0000, 4'hF);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(6);
    load_valid = 1'b1;
    load_data  = 16'h1234;
    chk("ready_idle", 32'(load_ready), 32'd1);
    tick(1);
    chk("ready_drop", 32'(load_ready), 32'd0);
    push(16'h1234, 4'hF);
    load_data = 16'hABCD;
    g = 0;
    while (!frame_start && g < 40) begin
      chk("ready_held_low", 32'(load_ready), 32'd0);
      tick(1);
      g++;
    end
    chk("ready_after_fb", 32'(load_ready), 32'd1);
    push(16'hABCD, 4'hF);
    tick(1);
    chk("ready_drop2", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    sync_frame();
    push(16'hABCD, 4'hF);
    tick(23);
    load_valid = 1'b1;
    load_data  = 16'h00FF;
    chk("ready_pre_fb", 32'(load_ready), 32'd1);
    tick(1);
    chk("fb_edge_fs", 32'(frame_start), 32'd1);
    chk("fb_edge_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    push(16'h00FF, 4'b0101);
    sync_frame();
    digit_en = 4'b0101;
    push(16'h00FF, 4'hF);
    sync_frame();
    digit_en   = 4'hF;
    load_valid = 1'b1;
    load_data  = 16'h0042;
    chk("ready_0042", 32'(load_ready), 32'd1);
    tick(1);
    load_valid = 1'b0;
    chk("drop_0042", 32'(load_ready), 32'd0);
    push(16'h0042, 4'hF);
    sync_frame();
    chk("ready_back", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data  = 16'h0000;
    tick(1);
    load_valid = 1'b0;
    chk("drop_0000", 32'(load_ready), 32'd0);
    push(16'h0000, 4'hF);
    sync_frame();
    tick(3);
    load_valid = 1'b1;
    load_data  = 16'h5555;
    tick(1);
    load_valid = 1'b0;
    chk("drop_5555", 32'(load_ready), 32'd0);
    tick(5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_an_n", 32'(an_n), 32'hF);
    chk("mid_rst_seg", 32'(seg_out), 32'h0);
    chk("mid_rst_ready", 32'(load_ready), 32'd1);
    chk("mid_rst_nibble", 32'(dec_nibble), 32'h0);
    push(16'h0000, 4'hF);
    tick(2);
    @(posedge clk);
    #2 rst_n = 1'b1;
    push(16'h0000, 4'hF);
    sync_frame();
    tick(20);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
